// File: rtl/l0_feeder_pkg.sv
// Shared definitions for the L0 feeder: default geometry, FSM encoding and vector width.
package l0_feeder_pkg;

    localparam int ROW_DEFAULT    = 8;
    localparam int BW_DEFAULT     = 4;
    localparam int ADDR_W_DEFAULT = 11;
    localparam int VEC_W          = ROW_DEFAULT * BW_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/l0_feeder_skid.sv
// One-entry skid register that holds a returning SRAM vector while L0 cannot accept it.
module l0_feeder_skid
    import l0_feeder_pkg::*;
#(
    parameter int width = VEC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [width-1:0] i_load_data,
    input  logic             i_unload,
    output logic             o_valid,
    output logic [width-1:0] o_data
);

    logic             r_valid;
    logic [width-1:0] r_data;

    // A load in the same cycle as an unload replaces the departing entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/l0_feeder.sv
// Streams num_vec consecutive SRAM vectors into the L0 buffer, absorbing L0 backpressure
// with a one-entry skid so no returning read is ever lost.
module l0_feeder
    import l0_feeder_pkg::*;
#(
    parameter int row    = ROW_DEFAULT,
    parameter int bw     = BW_DEFAULT,
    parameter int addr_w = ADDR_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addr_w-1:0]   base_addr,
    input  logic [addr_w:0]     num_vec,
    output logic                sram_cen,
    output logic                sram_wen,
    output logic [addr_w-1:0]   sram_addr,
    input  logic [row*bw-1:0]   sram_rdata,
    output logic [row*bw-1:0]   l0_in,
    output logic                l0_wr,
    input  logic                l0_full,
    output logic                busy,
    output logic                done
);

    localparam int VW = row * bw;

    state_t            r_state;
    state_t            w_next;
    logic [addr_w-1:0] r_base;
    logic [addr_w:0]   r_num;
    logic [addr_w:0]   r_cnt;
    logic              r_rvalid;

    logic              w_issue;
    logic              w_last_issue;
    logic [addr_w:0]   w_cnt_inc;
    logic [addr_w-1:0] w_issue_addr;
    logic              w_skid_valid;
    logic [VW-1:0]     w_skid_data;
    logic              w_skid_load;
    logic              w_skid_unload;
    logic              w_src_valid;
    logic [VW-1:0]     w_src_data;
    logic              w_busy;
    logic              w_done;

    // Only issue when the returning vector is guaranteed a home: either L0 or an empty skid.
    assign w_issue      = (r_state == ST_FETCH) && (r_cnt < r_num) && !w_skid_valid
                          && !(r_rvalid && l0_full);
    assign w_cnt_inc    = r_cnt + {{addr_w{1'b0}}, 1'b1};
    assign w_last_issue = w_issue && (w_cnt_inc == r_num);
    assign w_issue_addr = r_base + r_cnt[addr_w-1:0];

    assign sram_cen  = !w_issue;
    assign sram_wen  = 1'b1;
    assign sram_addr = w_issue ? w_issue_addr : '0;

    // The skid is older than any returning data, so it always drains first.
    assign w_skid_load   = r_rvalid && (l0_full || w_skid_valid);
    assign w_skid_unload = w_skid_valid && !l0_full;
    assign w_src_valid   = w_skid_valid || r_rvalid;
    assign w_src_data    = w_skid_valid ? w_skid_data : sram_rdata;

    assign l0_wr = w_src_valid && !l0_full;
    assign l0_in = l0_wr ? w_src_data : '0;
    assign busy  = w_busy;
    assign done  = w_done;

    l0_feeder_skid #(
        .width (VW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (reset),
        .i_load      (w_skid_load),
        .i_load_data (sram_rdata),
        .i_unload    (w_skid_unload),
        .o_valid     (w_skid_valid),
        .o_data      (w_skid_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_base   <= '0;
            r_num    <= '0;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rvalid <= w_issue;
            if ((r_state == ST_IDLE) && start && (num_vec != '0)) begin
                r_base <= base_addr;
                r_num  <= num_vec;
                r_cnt  <= '0;
            end else if (w_issue) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (num_vec == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_busy = 1'b1;
                if (w_last_issue) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (!r_rvalid && !w_skid_valid) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: doc/l0_feeder.md
L0_FEEDER -- requirements
Module: l0_feeder

Interface
REQ-001 Parameter row, default 8: number of L0 rows, i.e. lanes per vector.
REQ-002 Parameter bw, default 4: bits per lane.
REQ-003 Parameter addr_w, default 11: SRAM address width.
REQ-004 clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that launches a transfer; honoured only in IDLE.
REQ-007 base_addr  input  addr_w  first SRAM address of the transfer; sampled on start.
REQ-008 num_vec  input  addr_w+1  number of vectors to move; sampled on start.
REQ-009 sram_cen  output  1  SRAM chip enable, active-low.
REQ-010 sram_wen  output  1  SRAM write enable, active-low; held at 1 (read only).
REQ-011 sram_addr  output  addr_w  SRAM read address.
REQ-012 sram_rdata  input  row*bw  SRAM read data, valid exactly 1 cycle after sram_cen=0.
REQ-013 l0_in  output  row*bw  vector to L0; lane r occupies bits [(r+1)*bw-1 : r*bw].
REQ-014 l0_wr  output  1  L0 write strobe; one vector is written per high cycle.
REQ-015 l0_full  input  1  L0 o_full; when high, l0_wr shall be low.
REQ-016 busy  output  1  high in FETCH and DRAIN.
REQ-017 done  output  1  one-cycle pulse when the transfer completes.

Function
REQ-018 FSM states: IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE, start=1, num_vec>0: latch base_addr/num_vec, clear issue count, go to FETCH.
REQ-020 IDLE, start=1, num_vec=0: go straight to DONE with no SRAM access.
REQ-021 start outside IDLE is ignored.
REQ-022 Read issue in FETCH requires all of: issue count < num_vec; skid empty; not (rvalid=1 and l0_full=1).
REQ-023 On issue: sram_cen=0 and sram_addr=base+issue count; the issue count then increments.
REQ-024 Address arithmetic wraps modulo 2^addr_w.
REQ-025 rvalid is a register set in the cycle after an issue; sram_rdata is used only when rvalid=1.
REQ-026 Write priority: the skid entry goes first, then returning rdata; l0_wr=1 only when the selected source is valid and l0_full=0.
REQ-027 rdata that arrives while l0_full=1, or while the skid is occupied, is captured into the skid.
REQ-028 The issue rule guarantees the skid never overflows; no vector is ever dropped or duplicated.
REQ-029 Vectors reach L0 in address order with lanes unmodified.
REQ-030 FETCH goes to DRAIN in the cycle after the last issue.
REQ-031 DRAIN goes to DONE when rvalid=0 and the skid is empty.
REQ-032 DONE raises done=1 for exactly one cycle, then goes to IDLE.
REQ-033 Throughput: with l0_full held at 0, one vector per cycle; the first l0_wr occurs 1 cycle after the first issue.
REQ-034 l0_full may toggle in any cycle; behaviour follows REQ-022 and REQ-026 to REQ-027 without a stall deadlock.

Reset
REQ-035 While reset=0, asynchronously: state=IDLE, sram_cen=1, sram_wen=1, sram_addr=0, l0_in=0, l0_wr=0, busy=0, done=0, rvalid=0, skid empty, counters=0.
REQ-036 Reset mid-transfer abandons the transfer and emits no done pulse.
REQ-037 Reset mid-transfer does not write partial data to L0 after reset deassertion.

Structure
REQ-038 Shared package l0_feeder_pkg holds the row/bw/addr_w defaults, the FSM state encoding and the vector-width constant row*bw.
REQ-039 Single sub-module l0_feeder_skid: a 1-entry skid register with valid flag, load and unload ports, and asynchronous active-low reset.

Verification
REQ-040 Bench SRAM model: 1-cycle latency, mem[a] = {8 lanes of a[3:0]}. L0 model: 8-deep, with o_full.
REQ-041 Free flow: base=0, num=8, l0_full=0 -> l0_wr high for 8 consecutive cycles carrying addresses 0..7 in order; done 1 cycle after DRAIN exits; busy low afterwards.
REQ-042 Backpressure: base=16, num=8, l0_full=1 for cycles 3-6 after the first issue -> no l0_wr while full; all 8 vectors (addresses 16..23) written once each, in order.
REQ-043 Zero length: num=0 -> done pulses within 2 cycles; sram_cen stays 1; no l0_wr.
REQ-044 Wrap: base=2046, num=4, addr_w=11 -> addresses 2046, 2047, 0, 1 issued in that order.
REQ-045 Reset mid-run: reset=0 after 3 writes of num=8 -> all outputs at their reset values immediately; no done pulse; a new start then completes normally.
REQ-046 Start while busy: a second start in FETCH -> ignored; the exact num_vec count of the first transfer is written.
